vga_timing_gen: RTL and testbench

Parametrised VGA timing generator, successor to the fixed XGA (1024x768 @ 65 MHz) timing block. Produces horizontal/vertical pixel counters, blanking and sync flags for any mode set by parameters. Adds a pixel-clock enable for divided pixel rates, selectable sync polarity, and line/frame start strobes. Sits at the head of the video pipeline; drawing stages consume its counts and flags.

---
 rtl/vga_timing_gen.sv | 98 +++++++++
 tb/tb_vga_timing_gen.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel/line counters, blanking, sync and
// line/frame start strobes, all registered and advanced only on en.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 1024,
  parameter int H_FP      = 24,
  parameter int H_SYNC    = 136,
  parameter int H_BP      = 160,
  parameter int V_ACTIVE  = 768,
  parameter int V_FP      = 3,
  parameter int V_SYNC    = 6,
  parameter int V_BP      = 29,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1,
  parameter int CNT_W     = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hblnk,
  output logic             vblnk,
  output logic             hsync,
  output logic             vsync,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HSYNC_START = H_ACTIVE + H_FP;
  localparam int HSYNC_STOP  = HSYNC_START + H_SYNC - 1;
  localparam int VSYNC_START = V_ACTIVE + V_FP;
  localparam int VSYNC_STOP  = VSYNC_START + V_SYNC - 1;

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_LO   = CNT_W'(HSYNC_START);
  localparam logic [CNT_W-1:0] HS_HI   = CNT_W'(HSYNC_STOP);
  localparam logic [CNT_W-1:0] VS_LO   = CNT_W'(VSYNC_START);
  localparam logic [CNT_W-1:0] VS_HI   = CNT_W'(VSYNC_STOP);

  if (H_SYNC == 0 || V_SYNC == 0 || H_ACTIVE == 0 || V_ACTIVE == 0) begin : g_bad_zero
    $error("vga_timing_gen: H_SYNC, V_SYNC, H_ACTIVE and V_ACTIVE must be non-zero");
  end
  if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_width
    $error("vga_timing_gen: CNT_W too small for H_TOTAL/V_TOTAL");
  end

  logic             h_wrap;
  logic             v_wrap;
  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] v_nxt;
  logic             hblnk_nxt;
  logic             vblnk_nxt;
  logic             hsync_nxt;
  logic             vsync_nxt;

  // Flags are derived from the next counts so they land in the same cycle as the counts.
  always_comb begin
    h_wrap    = (hcount >= H_LAST);
    v_wrap    = (vcount >= V_LAST);
    h_nxt     = h_wrap ? '0 : hcount + CNT_W'(1);
    v_nxt     = vcount;
    if (h_wrap) begin
      v_nxt = v_wrap ? '0 : vcount + CNT_W'(1);
    end
    hblnk_nxt = (h_nxt >= H_ACT_C);
    vblnk_nxt = (v_nxt >= V_ACT_C);
    hsync_nxt = ~(((h_nxt >= HS_LO) && (h_nxt <= HS_HI)) ^ HSYNC_POL);
    vsync_nxt = ~(((v_nxt >= VS_LO) && (v_nxt <= VS_HI)) ^ VSYNC_POL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount      <= '0;
      vcount      <= '0;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      hcount      <= h_nxt;
      vcount      <= v_nxt;
      hblnk       <= hblnk_nxt;
      vblnk       <= vblnk_nxt;
      hsync       <= hsync_nxt;
      vsync       <= vsync_nxt;
      line_start  <= h_wrap;
      frame_start <= h_wrap & v_wrap;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: XGA, small and inverted-polarity modes checked each
// cycle against a frame-position model, plus literal spot checks.
module tb_vga_timing_gen;

  localparam int X_FRAME = 1344 * 806;
  localparam int S_FRAME = 15 * 8;
  localparam int N_FRAME = 28 * 13;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_x = 1'b0, en_s = 1'b0, en_n = 1'b0;
  logic run = 1'b0;

  logic [10:0] x_hc, x_vc;
  logic [3:0]  s_hc, s_vc;
  logic [4:0]  n_hc, n_vc;
  logic x_hb, x_vb, x_hs, x_vs, x_ls, x_fs;
  logic s_hb, s_vb, s_hs, s_vs, s_ls, s_fs;
  logic n_hb, n_vb, n_hs, n_vs, n_ls, n_fs;

  int checks = 0;
  int passes = 0;

  int px = 0, ps = 0, pn = 0;
  bit stx = 1'b0, sts = 1'b0, stn = 1'b0;

  always #5 clk = ~clk;

  vga_timing_gen u_xga (
    .clk(clk), .rst(rst), .en(en_x), .hcount(x_hc), .vcount(x_vc),
    .hblnk(x_hb), .vblnk(x_vb), .hsync(x_hs), .vsync(x_vs),
    .line_start(x_ls), .frame_start(x_fs));

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .CNT_W(4)) u_sml (
    .clk(clk), .rst(rst), .en(en_s), .hcount(s_hc), .vcount(s_vc),
    .hblnk(s_hb), .vblnk(s_vb), .hsync(s_hs), .vsync(s_vs),
    .line_start(s_ls), .frame_start(s_fs));

  vga_timing_gen #(.H_ACTIVE(16), .H_FP(3), .H_SYNC(5), .H_BP(4),
                   .V_ACTIVE(6), .V_FP(2), .V_SYNC(3), .V_BP(2),
                   .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CNT_W(5)) u_neg (
    .clk(clk), .rst(rst), .en(en_n), .hcount(n_hc), .vcount(n_vc),
    .hblnk(n_hb), .vblnk(n_vb), .hsync(n_hs), .vsync(n_vs),
    .line_start(n_ls), .frame_start(n_fs));

  function automatic logic [27:0] pack(int h, int v, bit hb, bit vb, bit hs, bit vs, bit ls, bit fs);
    return {11'(h), 11'(v), hb, vb, hs, vs, ls, fs};
  endfunction

  // Expected outputs from the linear pixel index within the frame.
  function automatic logic [27:0] model(int p, bit st, int ha, int hfp, int hsw, int hbp,
                                        int va, int vfp, int vsw, int vbp, bit hpol, bit vpol);
    int ht = ha + hfp + hsw + hbp;
    int h = p % ht;
    int v = p / ht;
    bit hact = (h >= ha + hfp) && (h < ha + hfp + hsw);
    bit vact = (v >= va + vfp) && (v < va + vfp + vsw);
    return pack(h, v, h >= ha, v >= va, hact ? hpol : !hpol, vact ? vpol : !vpol,
                st && (h == 0), st && (p == 0));
  endfunction

  function automatic logic [27:0] obs_x();
    return {x_hc, x_vc, x_hb, x_vb, x_hs, x_vs, x_ls, x_fs};
  endfunction
  function automatic logic [27:0] obs_s();
    return {11'(s_hc), 11'(s_vc), s_hb, s_vb, s_hs, s_vs, s_ls, s_fs};
  endfunction
  function automatic logic [27:0] obs_n();
    return {11'(n_hc), 11'(n_vc), n_hb, n_vb, n_hs, n_vs, n_ls, n_fs};
  endfunction

  task automatic check(string name, logic [27:0] got, logic [27:0] req);
    checks++;
    if (got === req) passes++;
    else $display("FAIL %s at %0t: got h=%0d v=%0d flags=%b, required h=%0d v=%0d flags=%b",
                  name, $time, got[27:17], got[16:6], got[5:0], req[27:17], req[16:6], req[5:0]);
  endtask

  task automatic check_int(string name, int got, int req);
    checks++;
    if (got == req) passes++;
    else $display("FAIL %s: got %0d, required %0d", name, got, req);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      px <= 0; ps <= 0; pn <= 0;
      stx <= 1'b0; sts <= 1'b0; stn <= 1'b0;
    end else begin
      if (en_x) begin px <= (px + 1) % X_FRAME; stx <= 1'b1; end
      if (en_s) begin ps <= (ps + 1) % S_FRAME; sts <= 1'b1; end
      if (en_n) begin pn <= (pn + 1) % N_FRAME; stn <= 1'b1; end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      check("model_xga", obs_x(), model(px, stx, 1024, 24, 136, 160, 768, 3, 6, 29, 1'b1, 1'b1));
      check("model_sml", obs_s(), model(ps, sts, 8, 2, 3, 2, 4, 1, 2, 1, 1'b1, 1'b1));
      check("model_neg", obs_n(), model(pn, stn, 16, 3, 5, 4, 6, 2, 3, 2, 1'b0, 1'b0));
    end
  end

  initial begin
    int rise1, rise2;
    bit prev_fs;
    run = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_xga", obs_x(), pack(0, 0, 0, 0, 0, 0, 0, 0));
    check("rst_sml", obs_s(), pack(0, 0, 0, 0, 0, 0, 0, 0));
    check("rst_neg", obs_n(), pack(0, 0, 0, 0, 1, 1, 0, 0));
    #2 rst = 1'b0;

    // Free-running XGA and small mode; random enable on the inverted-polarity mode.
    rise1 = -1; rise2 = -1; prev_fs = 1'b0;
    for (int i = 1; i <= 4100; i++) begin
      en_x = 1'b1;
      en_s = 1'b1;
      en_n = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      case (i)
        1:    check("xga_first_edge", obs_x(), pack(1, 0, 0, 0, 0, 0, 0, 0));
        1023: check("xga_last_active", obs_x(), pack(1023, 0, 0, 0, 0, 0, 0, 0));
        1024: check("xga_hblnk_rise", obs_x(), pack(1024, 0, 1, 0, 0, 0, 0, 0));
        1047: check("xga_pre_hsync", obs_x(), pack(1047, 0, 1, 0, 0, 0, 0, 0));
        1048: check("xga_hsync_start", obs_x(), pack(1048, 0, 1, 0, 1, 0, 0, 0));
        1183: check("xga_hsync_stop", obs_x(), pack(1183, 0, 1, 0, 1, 0, 0, 0));
        1184: check("xga_post_hsync", obs_x(), pack(1184, 0, 1, 0, 0, 0, 0, 0));
        1343: check("xga_line_end", obs_x(), pack(1343, 0, 1, 0, 0, 0, 0, 0));
        1344: check("xga_line_wrap", obs_x(), pack(0, 1, 0, 0, 0, 0, 1, 0));
        1345: check("xga_ls_clear", obs_x(), pack(1, 1, 0, 0, 0, 0, 0, 0));
        2688: check("xga_line2", obs_x(), pack(0, 2, 0, 0, 0, 0, 1, 0));
        default: ;
      endcase
      case (i)
        10:  check("sml_hsync", obs_s(), pack(10, 0, 1, 0, 1, 0, 0, 0));
        60:  check("sml_vblnk_wrap", obs_s(), pack(0, 4, 0, 1, 0, 0, 1, 0));
        75:  check("sml_vsync_line", obs_s(), pack(0, 5, 0, 1, 0, 1, 1, 0));
        80:  check("sml_vsync_mid", obs_s(), pack(5, 5, 0, 1, 0, 1, 0, 0));
        119: check("sml_corner", obs_s(), pack(14, 7, 1, 1, 0, 0, 0, 0));
        120: check("sml_frame_wrap", obs_s(), pack(0, 0, 0, 0, 0, 0, 1, 1));
        default: ;
      endcase
      if (s_fs && !prev_fs) begin
        if (rise1 < 0) rise1 = i;
        else if (rise2 < 0) rise2 = i;
      end
      prev_fs = s_fs;
    end
    check_int("sml_frame_period", (rise1 < 0 || rise2 < 0) ? -1 : rise2 - rise1, 120);

    // Mid-line asynchronous reset with en still high.
    #2 rst = 1'b1;
    #1;
    check("midrst_xga", obs_x(), pack(0, 0, 0, 0, 0, 0, 0, 0));
    check("midrst_neg", obs_n(), pack(0, 0, 0, 0, 1, 1, 0, 0));
    @(negedge clk);
    #2 rst = 1'b0;

    // Alternating enable on the small mode doubles its frame period.
    rise1 = -1; rise2 = -1; prev_fs = 1'b0;
    for (int i = 1; i <= 600; i++) begin
      en_x = 1'b1;
      en_s = 1'(i % 2);
      en_n = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      case (i)
        1:   check("midrst_first_edge", obs_x(), pack(1, 0, 0, 0, 0, 0, 0, 0));
        2:   check("half_hold", obs_s(), pack(1, 0, 0, 0, 0, 0, 0, 0));
        239: check("half_frame_wrap", obs_s(), pack(0, 0, 0, 0, 0, 0, 1, 1));
        240: check("half_strobe_held", obs_s(), pack(0, 0, 0, 0, 0, 0, 1, 1));
        241: check("half_strobe_clear", obs_s(), pack(1, 0, 0, 0, 0, 0, 0, 0));
        default: ;
      endcase
      if (s_fs && !prev_fs) begin
        if (rise1 < 0) rise1 = i;
        else if (rise2 < 0) rise2 = i;
      end
      prev_fs = s_fs;
    end
    check_int("half_frame_period", (rise1 < 0 || rise2 < 0) ? -1 : rise2 - rise1, 240);

    run = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
